tmds_encoder_mc: RTL and testbench
==================================

TMDS_ENCODER_MC -- requirements
Module: tmds_encoder_mc

Interface
REQ-001 Parameter CHANNELS, default 3, meaning number of independent TMDS lanes encoded in parallel (1..8).
REQ-002 Parameter GUARD_CH_SEL, default 0, meaning lane index whose guard-band pattern is the ch0 variant; the other lanes use the ch1/ch2 variant.
REQ-003 i_hdmi_clk  input  1  pixel clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_mode  input  3  period type: 0 CTRL, 1 VIDEO, 2 VIDEO_GUARD, 3 DATA_ISLAND, 4 DATA_GUARD, 5..7 treated as CTRL.
REQ-006 i_data  input  8*CHANNELS  pixel byte per lane, lane n at [8n+7:8n].
REQ-007 i_ctrl  input  2*CHANNELS  control bits {c1,c0} per lane.
REQ-008 i_aux  input  4*CHANNELS  TERC4 nibble per lane.
REQ-009 o_tmds  output  10*CHANNELS  encoded symbol per lane, bit 0 transmitted first.
REQ-010 o_bias  output  5*CHANNELS  signed running disparity per lane, for debug.

Function
REQ-011 Latency SHALL be exactly 2 cycles from inputs to o_tmds for every mode; i_mode is pipelined alongside the data.
REQ-012 Stage 1 SHALL compute the 9-bit transition-minimised word per lane: XNOR chain when popcount(data)>4, or popcount==4 with data[0]=0; otherwise XOR chain; bit 8 = 1 for XOR, 0 for XNOR.
REQ-013 Stage 2, VIDEO: when bias==0 or word balance==0, output {~q8, q8, q8 ? q[7:0] : ~q[7:0]}; bias += q8 ? balance : -balance.
REQ-014 Stage 2, VIDEO, otherwise: invert q[7:0] and set bit 9 when sign(bias)==sign(balance); bias updated per DVI 1.0 rule including the 2*q8 correction term.
REQ-015 Bias SHALL be 5-bit two's complement; each lane's bias SHALL stay within -8..+8 for any input sequence.
REQ-016 CTRL: {c1,c0} 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (bit 9 first).
REQ-017 VIDEO_GUARD: the GUARD_CH_SEL lane outputs 1011001100; the other lanes output 0100110011.
REQ-018 DATA_ISLAND: each lane outputs the TERC4 code of its i_aux nibble per HDMI 1.4b Table 5-18.
REQ-019 DATA_GUARD: the GUARD_CH_SEL lane outputs the TERC4 code of its i_aux; the other lanes output 0100110011.
REQ-020 Any non-VIDEO symbol reaching stage 2 SHALL clear that lane's bias to 0 in the same cycle.
REQ-021 Mode changes SHALL take effect on any cycle with no bubble; VIDEO following a non-VIDEO cycle starts from bias 0.
REQ-022 Lanes SHALL be fully independent; no lane's data affects another lane's output or bias.

Reset
REQ-023 While i_reset_n=0, all pipeline registers SHALL clear asynchronously: o_tmds = 1101010100 per lane, o_bias = 0, staged mode = CTRL.
REQ-024 Release SHALL be sampled synchronously: the first encoded input appears on o_tmds 2 cycles after the first rising edge with i_reset_n=1.
REQ-025 Reset asserted mid-VIDEO SHALL discard in-flight symbols; no partial symbol is emitted.

Configuration
REQ-026 Macro TMDS_ENCODER_MC_TERC4_EN, when defined: DATA_ISLAND and DATA_GUARD behave per REQ-018/019, and the TERC4 lookup is compiled in.
REQ-027 Without TMDS_ENCODER_MC_TERC4_EN: modes 3 and 4 are treated as CTRL, i_aux is ignored, no TERC4 logic is synthesised, and the rest of the behaviour is unchanged.

Verification
REQ-028 Hold reset, then release with mode=CTRL, ctrl=01 on lane 0 -> o_tmds lane0 = 1101010100 until 2 cycles after release, then 0010101011.
REQ-029 VIDEO, data=0x00 for 4 cycles from bias 0 -> first symbol 0100000000 (bit 9 first); bias stays within +-8; o_bias alternates as required by REQ-014.
REQ-030 Random VIDEO data for 10^5 cycles, all lanes -> every output decodes back to its input; |bias|<=8 throughout; matches golden model bit-exact.
REQ-031 VIDEO for 3 cycles, then VIDEO_GUARD for 2 cycles, then VIDEO -> guard symbols per REQ-017; o_bias=0 on guard cycles; the first video symbol after the guard uses the bias==0 branch.
REQ-032 With TERC4_EN, DATA_ISLAND sweeping aux 0..15 -> Table 5-18 codes 2 cycles later; without TERC4_EN, the same stimulus -> CTRL codes.
REQ-033 Assert reset mid-VIDEO at an arbitrary phase -> o_tmds = 1101010100 and o_bias = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS / TERC4 encoder, two-stage pipeline, per-lane running disparity.
// Define TMDS_ENCODER_MC_TERC4_EN to compile in the DATA_ISLAND / DATA_GUARD modes.
module tmds_encoder_mc #(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned GUARD_CH_SEL = 0
) (
    input  logic                   i_hdmi_clk,
    input  logic                   i_reset_n,
    input  logic [2:0]             i_mode,
    input  logic [8*CHANNELS-1:0]  i_data,
    input  logic [2*CHANNELS-1:0]  i_ctrl,
    input  logic [4*CHANNELS-1:0]  i_aux,
    output logic [10*CHANNELS-1:0] o_tmds,
    output logic [5*CHANNELS-1:0]  o_bias
);
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned BIAS_W = 5;

    localparam logic [SYM_W-1:0] CTRL_00   = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01   = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10   = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11   = 10'b1010101011;
    localparam logic [SYM_W-1:0] GUARD_CH0 = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_CHX = 10'b0100110011;

    typedef enum logic [2:0] {
        MD_CTRL   = 3'd0,
        MD_VIDEO  = 3'd1,
        MD_VGUARD = 3'd2,
        MD_DATA   = 3'd3,
        MD_DGUARD = 3'd4
    } mode_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Transition-minimised 9-bit word; bit 8 set when the XOR chain was used.
    function automatic logic [8:0] min_transitions(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [SYM_W-1:0] ctrl_code(input logic [1:0] c);
        logic [SYM_W-1:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

`ifdef TMDS_ENCODER_MC_TERC4_EN
    function automatic logic [SYM_W-1:0] terc4(input logic [3:0] a);
        logic [SYM_W-1:0] s;
        case (a)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'ha:    s = 10'b0110011100;
            4'hb:    s = 10'b1011000110;
            4'hc:    s = 10'b1010001110;
            4'hd:    s = 10'b1001110001;
            4'he:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`else
    logic unused_aux;
    assign unused_aux = ^i_aux;
`endif

    mode_e mode_d;
    mode_e mode_s1;

    // Reserved and (when TERC4 is absent) data-island codes collapse to CTRL here.
    always_comb begin
        mode_d = MD_CTRL;
        case (i_mode)
            3'd1:    mode_d = MD_VIDEO;
            3'd2:    mode_d = MD_VGUARD;
`ifdef TMDS_ENCODER_MC_TERC4_EN
            3'd3:    mode_d = MD_DATA;
            3'd4:    mode_d = MD_DGUARD;
`endif
            default: mode_d = MD_CTRL;
        endcase
    end

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) mode_s1 <= MD_CTRL;
        else            mode_s1 <= mode_d;
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        localparam bit IS_GUARD_LANE = (n == int'(GUARD_CH_SEL));

        logic [8:0]        qm_s1;
        logic [1:0]        ctrl_s1;
        logic [SYM_W-1:0]  sym;
        logic [SYM_W-1:0]  sym_d;
        logic [BIAS_W-1:0] bias;
        logic [BIAS_W-1:0] bias_d;
        logic [3:0]        ones;
        logic [BIAS_W-1:0] bal;

        always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                qm_s1   <= '0;
                ctrl_s1 <= '0;
            end else begin
                qm_s1   <= min_transitions(i_data[8*n +: 8]);
                ctrl_s1 <= i_ctrl[2*n +: 2];
            end
        end

`ifdef TMDS_ENCODER_MC_TERC4_EN
        logic [3:0] aux_s1;
        always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
            if (!i_reset_n) aux_s1 <= '0;
            else            aux_s1 <= i_aux[4*n +: 4];
        end
`endif

        // Word balance (ones minus zeros) in 5-bit two's complement.
        assign ones = popcount8(qm_s1[7:0]);
        assign bal  = {ones, 1'b0} - 5'd8;

        always_comb begin
            sym_d  = CTRL_00;
            bias_d = '0;
            case (mode_s1)
                MD_VIDEO: begin
                    if ((bias == '0) || (bal == '0)) begin
                        sym_d  = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
                        bias_d = qm_s1[8] ? (bias + bal) : (bias - bal);
                    end else if (bias[BIAS_W-1] == bal[BIAS_W-1]) begin
                        sym_d  = {1'b1, qm_s1[8], ~qm_s1[7:0]};
                        bias_d = bias + {3'b000, qm_s1[8], 1'b0} - bal;
                    end else begin
                        sym_d  = {1'b0, qm_s1[8], qm_s1[7:0]};
                        bias_d = bias - {3'b000, ~qm_s1[8], 1'b0} + bal;
                    end
                end
                MD_VGUARD: sym_d = IS_GUARD_LANE ? GUARD_CH0 : GUARD_CHX;
`ifdef TMDS_ENCODER_MC_TERC4_EN
                MD_DATA:   sym_d = terc4(aux_s1);
                MD_DGUARD: sym_d = IS_GUARD_LANE ? terc4(aux_s1) : GUARD_CHX;
`endif
                default:   sym_d = ctrl_code(ctrl_s1);
            endcase
        end

        always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sym  <= CTRL_00;
                bias <= '0;
            end else begin
                sym  <= sym_d;
                bias <= bias_d;
            end
        end

        assign o_tmds[SYM_W*n +: SYM_W]   = sym;
        assign o_bias[BIAS_W*n +: BIAS_W] = bias;
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Scoreboard bench for tmds_encoder_mc: random stimulus, spec-level reference model,
// decoupled monitor; honours TMDS_ENCODER_MC_TERC4_EN like the design.
module tb_tmds_encoder_mc;
    localparam int unsigned CH   = 3;
    localparam int unsigned GSEL = 1;

    localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                            10'b0101010100, 10'b1010101011};
    localparam logic [9:0] G0 = 10'b1011001100;
    localparam logic [9:0] GX = 10'b0100110011;
`ifdef TMDS_ENCODER_MC_TERC4_EN
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        mode;
    logic [8*CH-1:0]   data;
    logic [2*CH-1:0]   ctrl;
    logic [4*CH-1:0]   aux;
    logic [10*CH-1:0]  tmds;
    logic [5*CH-1:0]   bias;

    tmds_encoder_mc #(.CHANNELS(CH), .GUARD_CH_SEL(GSEL)) dut (
        .i_hdmi_clk(clk),
        .i_reset_n (rst_n),
        .i_mode    (mode),
        .i_data    (data),
        .i_ctrl    (ctrl),
        .i_aux     (aux),
        .o_tmds    (tmds),
        .o_bias    (bias)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [10*CH-1:0] tmds;
        logic [5*CH-1:0]  bias;
        logic [8*CH-1:0]  data;
        bit              video;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   bias_m [CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Video symbol from the DVI rules, with the running disparity kept as a plain int.
    function automatic logic [9:0] ref_video(input int lane, input logic [7:0] d);
        int         ones;
        bit         use_xnor;
        logic [7:0] q;
        bit         q8;
        bit         inv;
        int         bal;
        int         b;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q8  = !use_xnor;
        bal = 2 * $countones(q) - 8;
        b   = bias_m[lane];
        if (b == 0 || bal == 0) begin
            inv = !q8;
            b   = b + (q8 ? bal : -bal);
        end else if ((b > 0) == (bal > 0)) begin
            inv = 1'b1;
            b   = b + 2 * int'(q8) - bal;
        end else begin
            inv = 1'b0;
            b   = b + bal - 2 * int'(!q8);
        end
        bias_m[lane] = b;
        return {inv, q8, inv ? ~q : q};
    endfunction

    function automatic logic [9:0] ref_lane(input int lane, input logic [2:0] m, input logic [7:0] d,
                                            input logic [1:0] c, input logic [3:0] a);
        logic [9:0] sym;
        if (m == 3'd1) return ref_video(lane, d);
        bias_m[lane] = 0;
        sym = CTRL_TAB[c];
        if (m == 3'd2) sym = (lane == int'(GSEL)) ? G0 : GX;
`ifdef TMDS_ENCODER_MC_TERC4_EN
        if (m == 3'd3) sym = TERC4_TAB[a];
        if (m == 3'd4) sym = (lane == int'(GSEL)) ? TERC4_TAB[a] : GX;
`endif
        return sym;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic apply(input logic [2:0] m, input logic [8*CH-1:0] d,
                         input logic [2*CH-1:0] c, input logic [4*CH-1:0] a);
        exp_t e;
        mode = m; data = d; ctrl = c; aux = a;
        e.due   = cyc + 2;
        e.data  = d;
        e.video = (m == 3'd1);
        for (int n = 0; n < CH; n++) begin
            e.tmds[10*n +: 10] = ref_lane(n, m, d[8*n +: 8], c[2*n +: 2], a[4*n +: 4]);
            e.bias[5*n +: 5]   = 5'(bias_m[n]);
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic [2:0] m, input logic [8*CH-1:0] d,
                        input logic [2*CH-1:0] c, input logic [4*CH-1:0] a);
        @(negedge clk);
        apply(m, d, c, a);
    endtask

    task automatic step_rand(input logic [2:0] m);
        step(m, (8*CH)'($urandom), (2*CH)'($urandom), (4*CH)'($urandom));
    endtask

    // Release at a falling edge; the stage-1 registers still hold reset CTRL for one more output.
    task automatic release_reset(input logic [2*CH-1:0] c);
        exp_t e;
        @(negedge clk);
        rst_n   = 1'b1;
        e.due   = cyc + 1;
        e.tmds  = {CH{CTRL_TAB[0]}};
        e.bias  = '0;
        e.data  = '0;
        e.video = 1'b0;
        sb.push_back(e);
        apply(3'd0, (8*CH)'($urandom), c, (4*CH)'($urandom));
    endtask

    task automatic check_reset_now(input string name);
        for (int n = 0; n < CH; n++) begin
            check({name, "_tmds"}, 32'(tmds[10*n +: 10]), 32'(CTRL_TAB[0]));
            check({name, "_bias"}, 32'(bias[5*n +: 5]), 32'd0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   bv;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("latency", 32'(e.due), 32'(cyc));
                for (int n = 0; n < CH; n++) begin
                    check("tmds", 32'(tmds[10*n +: 10]), 32'(e.tmds[10*n +: 10]));
                    check("bias", 32'(bias[5*n +: 5]), 32'(e.bias[5*n +: 5]));
                    if (e.video) begin
                        bv = int'($signed(bias[5*n +: 5]));
                        check("bias_range", 32'(bv >= -8 && bv <= 8), 32'd1);
                        check("decode", 32'(tmds_decode(tmds[10*n +: 10])), 32'(e.data[8*n +: 8]));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [4*CH-1:0] a;
        logic [2*CH-1:0] c;
        int              r;
        rst_n = 1'b0;
        mode  = 3'd1;
        data  = (8*CH)'($urandom);
        ctrl  = '1;
        aux   = '0;
        for (int n = 0; n < CH; n++) bias_m[n] = 0;
        repeat (3) @(negedge clk);
        check_reset_now("reset_hold");

        // Release with lane 0 sending control 01.
        c = (2*CH)'($urandom);
        c[1:0] = 2'b01;
        release_reset(c);
        repeat (3) step(3'd0, (8*CH)'($urandom), c, (4*CH)'($urandom));

        // All-zero video from bias 0, then video / guard / video.
        repeat (4) step(3'd1, '0, '0, '0);
        step_rand(3'd0);
        repeat (3) step_rand(3'd1);
        repeat (2) step_rand(3'd2);
        repeat (3) step_rand(3'd1);

        // Data island and data guard sweeps over every nibble.
        for (int m = 3; m <= 4; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int n = 0; n < CH; n++) a[4*n +: 4] = 4'((i + n) % 16);
                step(3'(m), (8*CH)'($urandom), (2*CH)'($urandom), a);
            end
        end

        // Random mode mix, weighted toward video, including reserved codes.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 11));
            step_rand((r < 4) ? 3'd1 : 3'(r - 4));
        end

        // Reset asserted mid-video at an arbitrary phase must clear outputs at once.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(3, 20)) step_rand(3'd1);
            @(posedge clk);
            #($urandom_range(2, 8));
            rst_n = 1'b0;
            sb.delete();
            for (int n = 0; n < CH; n++) bias_m[n] = 0;
            #1;
            check_reset_now("reset_async");
            repeat (2) @(negedge clk);
            check_reset_now("reset_held");
            release_reset((2*CH)'($urandom));
        end

        // Long random video run.
        for (int i = 0; i < 20000; i++) step_rand(3'd1);
        repeat (2) step_rand(3'd0);

        repeat (4) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
